divu_sequencer: RTL and testbench

DIVU_SEQUENCER -- requirements
Module: divu_sequencer

---
 rtl/divu_sequencer_pkg.sv | 18 +
 rtl/divu_sequencer_div_step.sv | 23 ++
 rtl/divu_sequencer.sv | 112 +++++++++++
 tb/tb_divu_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/divu_sequencer_pkg.sv
// Shared definitions for the DIVU sequencer: FSM encoding, iteration count
// and the MIPS function codes that feed the divider and the HI/LO readers.
package divu_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  localparam logic [5:0] DIVU = 6'd27;
  localparam logic [5:0] MFHI = 6'd16;
  localparam logic [5:0] MFLO = 6'd18;

endpackage

// File: rtl/divu_sequencer_div_step.sv
// One restoring-division step: shift {rem,quo} left by one and subtract the
// divisor from the partial remainder when it fits.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        take;

  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, divisor};
  // rem < divisor always holds on entry, so a clear borrow bit means rem_sh >= divisor
  assign take   = ~diff[32];

  assign rem_n = take ? diff[31:0] : rem_sh[31:0];
  assign quo_n = {quo[30:0], take};

endmodule

// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned divider for the EX stage: resolves one quotient bit per
// cycle, strobes HI/LO once in DONE and stalls the pipe around it.
module divu_sequencer #(
  parameter int DIV_ITER = divu_sequencer_pkg::DIV_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        mf_req,
  output logic        stall,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic        div_zero
);

  import divu_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rem_q, quo_q, dvs_q;
  logic [31:0]      rem_n, quo_n;
  logic [31:0]      hi_q, lo_q;
  logic             dz_q;
  logic             div0;
  logic             last_step;

  assign div0      = (divisor == 32'd0);
  assign last_step = (cnt_q == LAST);

  div_step u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_n   (rem_n),
    .quo_n   (quo_n)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = div0 ? DONE : CALC;
      CALC: if (last_step) state_d = DONE;
      DONE: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign stall = (mf_req & (busy | start)) | (start & busy);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the working registers (rem/quo/divisor) are left out of reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && div0) begin
            hi_q <= dividend;
            lo_q <= 32'hFFFF_FFFF;
            dz_q <= 1'b1;
          end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 1'b1;
          // Result is published on the edge into DONE and held until the next division ends
          if (last_step) begin
            hi_q <= rem_n;
            lo_q <= quo_n;
            dz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_data  = hi_q;
  assign lo_data  = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divu_sequencer.sv
// Self-checking bench for divu_sequencer: table of directed divisions plus
// hand-written sequences for stall, reset abort and back-to-back starts.
module tb_divu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mf_req;
  logic        stall;
  logic        busy;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic        div_zero;

  int n_checks = 0;
  int n_errors = 0;

  divu_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .mf_req   (mf_req),
    .stall    (stall),
    .busy     (busy),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_data  (hi_data),
    .lo_data  (lo_data),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves the bench just after a rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc;
    bit  found;
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    @(negedge clk);
    check("stall_at_start", 32'(stall), 32'd0);
    next_cycle();
    start = 1'b0;
    cyc   = 1;
    found = 0;
    while (!found && cyc <= 40) begin
      @(negedge clk);
      if (hi_we) found = 1;
      else begin
        next_cycle();
        cyc++;
      end
    end
    check("latency", 32'(cyc), 32'(v.lat));
    check("lo_we", 32'(lo_we), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("quotient", lo_data, v.q);
    check("remainder", hi_data, v.r);
    check("div_zero", 32'(div_zero), 32'(v.dz));
    next_cycle();
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("hi_we_after_done", 32'(hi_we), 32'd0);
    check("lo_hold", lo_data, v.q);
    check("dz_hold", 32'(div_zero), 32'(v.dz));
    next_cycle();
  endtask

  initial begin
    int first_we;
    int n_we;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[2] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0, 33};
    vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
    vecs[5] = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
    vecs[7] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 33};
    vecs[8] = '{32'h1234_5678,  32'd1000,       32'd305419,     32'd896,        1'b0, 33};
    vecs[9] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1};

    rst      = 1'b1;
    start    = 1'b0;
    mf_req   = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi_we", 32'(hi_we), 32'd0);
    check("reset_hi_data", hi_data, 32'd0);
    check("reset_lo_data", lo_data, 32'd0);
    check("reset_div_zero", 32'(div_zero), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    next_cycle();

    foreach (vecs[i]) run_vec(vecs[i]);

    // mf_req raised in cycle 3 must stall through DONE and release in IDLE
    for (int cyc = 0; cyc <= 34; cyc++) begin
      start    = (cyc == 0);
      dividend = 32'd100;
      divisor  = 32'd7;
      mf_req   = (cyc >= 3);
      @(negedge clk);
      if (cyc >= 3) check($sformatf("mf_stall_c%0d", cyc), 32'(stall), 32'(cyc <= 33));
      next_cycle();
    end
    mf_req = 1'b0;

    // reset pulse in cycle 10 aborts; restart in cycle 11 finishes in cycle 44
    first_we = -1;
    for (int cyc = 0; cyc <= 45; cyc++) begin
      rst      = (cyc == 10);
      start    = (cyc == 0) || (cyc == 11);
      dividend = (cyc == 11) ? 32'd77 : 32'd1000;
      divisor  = (cyc == 11) ? 32'd5  : 32'd10;
      @(negedge clk);
      if (hi_we && first_we < 0) first_we = cyc;
      if (cyc == 11) check("abort_idle", 32'(busy), 32'd0);
      if (cyc == 12) check("restart_busy", 32'(busy), 32'd1);
      if (cyc == 44) begin
        check("restart_quo", lo_data, 32'd15);
        check("restart_rem", hi_data, 32'd2);
      end
      next_cycle();
    end
    rst   = 1'b0;
    start = 1'b0;
    check("abort_first_strobe", 32'(first_we), 32'd44);

    // second start held from cycle 5 waits for IDLE in cycle 34
    n_we = 0;
    for (int cyc = 0; cyc <= 68; cyc++) begin
      start    = (cyc == 0) || (cyc >= 5 && cyc <= 34);
      dividend = (cyc == 0) ? 32'd1000 : 32'hDEAD_BEEF;
      divisor  = (cyc == 0) ? 32'd7    : 32'h10;
      @(negedge clk);
      if (hi_we) n_we++;
      if (cyc >= 5 && cyc <= 33) check($sformatf("b2b_stall_c%0d", cyc), 32'(stall), 32'd1);
      if (cyc == 34) check("b2b_accept_stall", 32'(stall), 32'd0);
      if (cyc == 35) check("b2b_accept_busy", 32'(busy), 32'd1);
      if (cyc == 33) begin
        check("b2b_first_we", 32'(hi_we), 32'd1);
        check("b2b_first_quo", lo_data, 32'd142);
        check("b2b_first_rem", hi_data, 32'd6);
      end
      if (cyc == 67) begin
        check("b2b_second_we", 32'(hi_we), 32'd1);
        check("b2b_second_quo", lo_data, 32'h0DEA_DBEE);
        check("b2b_second_rem", hi_data, 32'hF);
      end
      next_cycle();
    end
    start = 1'b0;
    check("b2b_strobe_count", 32'(n_we), 32'd2);

    // reset wins over start at the same edge
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    next_cycle();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_over_start_busy", 32'(busy), 32'd0);
    check("rst_clears_lo", lo_data, 32'd0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
